// File: rtl/twofish_pkg.sv
// twofish_pkg: constants and helpers shared by the Twofish encryptor,
// decryptor and key schedule.
//   - q0/q1 byte permutations built from their 4-bit t-tables
//   - GF(2^8) multiply, MDS (poly 0x169) and RS (poly 0x14D) constants
//   - round count, decryptor FSM state encoding, 32-bit rotates
package twofish_pkg;

  localparam int unsigned TF_ROUNDS  = 16;
  localparam int unsigned TF_SUBKEYS = 40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WIN0  = 3'd1,
    ST_WIN1  = 3'd2,
    ST_ROUND = 3'd3,
    ST_WOUT0 = 3'd4,
    ST_WOUT1 = 3'd5
  } tf_dec_state_e;

  // t-tables, entry 0 in the most significant nibble
  localparam logic [63:0] TF_Q0_T0 = 64'h817D_6F32_0B59_ECA4;
  localparam logic [63:0] TF_Q0_T1 = 64'hECB8_1235_F4A6_709D;
  localparam logic [63:0] TF_Q0_T2 = 64'hBA5E_6D90_C8F3_2471;
  localparam logic [63:0] TF_Q0_T3 = 64'hD7F4_126E_9B30_85CA;
  localparam logic [63:0] TF_Q1_T0 = 64'h28BD_F76E_3194_0AC5;
  localparam logic [63:0] TF_Q1_T1 = 64'h1E2B_4C37_6DA5_F908;
  localparam logic [63:0] TF_Q1_T2 = 64'h4C75_169A_0ED8_2B3F;
  localparam logic [63:0] TF_Q1_T3 = 64'hB951_C3DE_647F_208A;

  // Field polynomials, low byte only (x^8 term implied)
  localparam logic [7:0] TF_MDS_POLY = 8'h69;
  localparam logic [7:0] TF_RS_POLY  = 8'h4D;

  // RS matrix rows (used by the key schedule for S0/S1)
  localparam logic [63:0] TF_RS_ROW0 = 64'h01A4_5587_5A58_DB9E;
  localparam logic [63:0] TF_RS_ROW1 = 64'hA456_82F3_1EC6_68E5;
  localparam logic [63:0] TF_RS_ROW2 = 64'h02A1_FCC1_47AE_3D19;
  localparam logic [63:0] TF_RS_ROW3 = 64'hA455_875A_58DB_9E03;

  function automatic logic [31:0] tf_rol(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tf_ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [3:0] tf_nib(input logic [63:0] t, input logic [3:0] i);
    logic [63:0] sh;
    sh = t >> {~i, 2'b00};
    return sh[3:0];
  endfunction

  function automatic logic [7:0] tf_q(input logic [63:0] t0, input logic [63:0] t1,
                                      input logic [63:0] t2, input logic [63:0] t3,
                                      input logic [7:0] x);
    logic [3:0] a1, b1, a2, b2, a3, b3;
    a1 = x[7:4] ^ x[3:0];
    b1 = x[7:4] ^ {x[0], x[3:1]} ^ {x[4], 3'b000};
    a2 = tf_nib(t0, a1);
    b2 = tf_nib(t1, b1);
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    return {tf_nib(t3, b3), tf_nib(t2, a3)};
  endfunction

  function automatic logic [7:0] tf_q0(input logic [7:0] x);
    return tf_q(TF_Q0_T0, TF_Q0_T1, TF_Q0_T2, TF_Q0_T3, x);
  endfunction

  function automatic logic [7:0] tf_q1(input logic [7:0] x);
    return tf_q(TF_Q1_T0, TF_Q1_T1, TF_Q1_T2, TF_Q1_T3, x);
  endfunction

  function automatic logic [7:0] tf_gf_mul(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] poly);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ poly) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // MDS matrix times byte vector z (z[7:0] is element 0)
  function automatic logic [31:0] tf_mds(input logic [31:0] z);
    logic [7:0] z0, z1, z2, z3;
    logic [7:0] y0, y1, y2, y3;
    z0 = z[7:0];
    z1 = z[15:8];
    z2 = z[23:16];
    z3 = z[31:24];
    y0 = z0 ^ tf_gf_mul(z1, 8'hEF, TF_MDS_POLY)
            ^ tf_gf_mul(z2, 8'h5B, TF_MDS_POLY) ^ tf_gf_mul(z3, 8'h5B, TF_MDS_POLY);
    y1 = tf_gf_mul(z0, 8'h5B, TF_MDS_POLY) ^ tf_gf_mul(z1, 8'hEF, TF_MDS_POLY)
            ^ tf_gf_mul(z2, 8'hEF, TF_MDS_POLY) ^ z3;
    y2 = tf_gf_mul(z0, 8'hEF, TF_MDS_POLY) ^ tf_gf_mul(z1, 8'h5B, TF_MDS_POLY)
            ^ z2 ^ tf_gf_mul(z3, 8'hEF, TF_MDS_POLY);
    y3 = tf_gf_mul(z0, 8'hEF, TF_MDS_POLY) ^ z1
            ^ tf_gf_mul(z2, 8'hEF, TF_MDS_POLY) ^ tf_gf_mul(z3, 8'h5B, TF_MDS_POLY);
    return {y3, y2, y1, y0};
  endfunction

endpackage

// File: rtl/twofish_g.sv
// twofish_g: combinational Twofish g-function for a 128-bit key (k=2):
// two keyed q-permutation layers, a final q layer, then the MDS multiply.
//   x  in  32  input word (byte 0 = x[7:0])
//   s0 in  32  S-box key word S0 (applied first)
//   s1 in  32  S-box key word S1 (applied second)
//   y  out 32  g(x)
module twofish_g
  import twofish_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] s0,
  input  logic [31:0] s1,
  output logic [31:0] y
);

  logic [7:0] w_z0, w_z1, w_z2, w_z3;

  always_comb begin
    w_z0 = tf_q1(tf_q0(tf_q0(x[7:0])   ^ s0[7:0])   ^ s1[7:0]);
    w_z1 = tf_q0(tf_q0(tf_q1(x[15:8])  ^ s0[15:8])  ^ s1[15:8]);
    w_z2 = tf_q1(tf_q1(tf_q0(x[23:16]) ^ s0[23:16]) ^ s1[23:16]);
    w_z3 = tf_q0(tf_q1(tf_q1(x[31:24]) ^ s0[31:24]) ^ s1[31:24]);
  end

  assign y = tf_mds({w_z3, w_z2, w_z1, w_z0});

endmodule

// File: rtl/twofish_decrypt.sv
// twofish_decrypt: iterative Twofish block decryptor, 128-bit key.
// One 128-bit ciphertext is captured on a button rising edge; the plaintext
// is registered on data_out and done pulses 20 cycles later.
//   clk, reset     clock, asynchronous active-high reset
//   button         start request (0->1 edge starts, ignored while busy)
//   data_in        ciphertext, word i = data_in[32i+31:32i]
//   s0, s1         S-box key words
//   subkey_idx     even subkey index requested (combinational)
//   subkey_a/b     K[subkey_idx], K[subkey_idx+1]
//   data_out       plaintext, same word mapping as data_in
//   busy, done     busy from capture to completion, one-cycle done pulse
// Optional macro TWOFISH_DEC_ZEROIZE_EN: working registers cleared the cycle
// after done, and subkey_idx held at 0 while idle.
module twofish_decrypt
  import twofish_pkg::*;
#(
  parameter int unsigned ROUNDS    = TF_ROUNDS,
  parameter int unsigned SUBKEY_AW = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 button,
  input  logic [127:0]         data_in,
  input  logic [31:0]          s0,
  input  logic [31:0]          s1,
  output logic [SUBKEY_AW-1:0] subkey_idx,
  input  logic [31:0]          subkey_a,
  input  logic [31:0]          subkey_b,
  output logic [127:0]         data_out,
  output logic                 busy,
  output logic                 done
);

  if (ROUNDS != 16) begin : g_rounds_check
    $error("twofish_decrypt supports ROUNDS=16 only");
  end

  tf_dec_state_e        r_state;
  logic [3:0]           r_round;
  logic [31:0]          r_r0, r_r1, r_r2, r_r3;
  logic                 r_btn_q;
  logic [127:0]         r_data_out;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_start;
  logic [31:0]          w_t0, w_t1;
  logic [31:0]          w_f0, w_f1;
  logic [31:0]          w_r2n, w_r3n;
  logic [SUBKEY_AW-1:0] w_idle_idx;
  logic [SUBKEY_AW-1:0] w_idx;

  assign w_start = button & ~r_btn_q;

  twofish_g u_g0 (
    .x  (r_r0),
    .s0 (s0),
    .s1 (s1),
    .y  (w_t0)
  );

  twofish_g u_g1 (
    .x  (tf_rol(r_r1, 8)),
    .s0 (s0),
    .s1 (s1),
    .y  (w_t1)
  );

  // Inverse round: undo ROR on R2 and ROL on R3 of the encryptor
  assign w_f0  = w_t0 + w_t1 + subkey_a;
  assign w_f1  = w_t0 + {w_t1[30:0], 1'b0} + subkey_b;
  assign w_r2n = tf_rol(r_r2, 1) ^ w_f0;
  assign w_r3n = tf_ror(r_r3 ^ w_f1, 1);

`ifdef TWOFISH_DEC_ZEROIZE_EN
  assign w_idle_idx = '0;
`else
  logic [SUBKEY_AW-1:0] r_idle_idx;

  // Idle index remembers the last request (WOUT1's index)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle_idx <= '0;
    end else if (r_state == ST_WOUT1) begin
      r_idle_idx <= SUBKEY_AW'(2);
    end
  end

  assign w_idle_idx = r_idle_idx;
`endif

  always_comb begin
    w_idx = w_idle_idx;
    case (r_state)
      ST_WIN0:  w_idx = SUBKEY_AW'(4);
      ST_WIN1:  w_idx = SUBKEY_AW'(6);
      ST_ROUND: w_idx = SUBKEY_AW'({r_round, 1'b0}) + SUBKEY_AW'(8);
      ST_WOUT0: w_idx = '0;
      ST_WOUT1: w_idx = SUBKEY_AW'(2);
      default:  w_idx = w_idle_idx;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_round    <= '0;
      r_r0       <= '0;
      r_r1       <= '0;
      r_r2       <= '0;
      r_r3       <= '0;
      r_btn_q    <= 1'b0;
      r_data_out <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_btn_q <= button;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
`ifdef TWOFISH_DEC_ZEROIZE_EN
          if (r_done) begin
            r_r0 <= '0;
            r_r1 <= '0;
            r_r2 <= '0;
            r_r3 <= '0;
          end
`endif
          // A capture in the same cycle overrides the zeroize clear
          if (w_start) begin
            {r_r3, r_r2, r_r1, r_r0} <= data_in;
            r_busy  <= 1'b1;
            r_state <= ST_WIN0;
          end
        end
        ST_WIN0: begin
          r_r0    <= r_r0 ^ subkey_a;
          r_r1    <= r_r1 ^ subkey_b;
          r_state <= ST_WIN1;
        end
        ST_WIN1: begin
          r_r2    <= r_r2 ^ subkey_a;
          r_r3    <= r_r3 ^ subkey_b;
          r_round <= 4'(ROUNDS - 1);
          r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          if (r_round == '0) begin
            // Last inverse round leaves halves in place: words are P0..P3 order
            r_r2    <= w_r2n;
            r_r3    <= w_r3n;
            r_state <= ST_WOUT0;
          end else begin
            r_r0    <= w_r2n;
            r_r1    <= w_r3n;
            r_r2    <= r_r0;
            r_r3    <= r_r1;
            r_round <= r_round - 4'd1;
          end
        end
        ST_WOUT0: begin
          // P0/P1 whitened in place so data_out can load in one step later
          r_r0    <= r_r0 ^ subkey_a;
          r_r1    <= r_r1 ^ subkey_b;
          r_state <= ST_WOUT1;
        end
        ST_WOUT1: begin
          r_data_out <= {r_r3 ^ subkey_b, r_r2 ^ subkey_a, r_r1, r_r0};
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign subkey_idx = w_idx;
  assign data_out   = r_data_out;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
